// File: rtl/conv1d_mac_engine.sv
// ============================================================================
// Module  : conv1d_mac_engine
// Purpose : 1-D convolution engine (full / valid modes). Walks the output
//           index, issues one X/Y read per cycle, accumulates signed products
//           at ACC_W precision and writes saturated Z_W-bit results.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module conv1d_mac_engine #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int ACC_W  = 32,
    parameter int Z_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_in,
    input  logic              mode_in,
    input  logic [ADDR_W-1:0] sizeX_in,
    input  logic [ADDR_W-1:0] sizeY_in,
    output logic [ADDR_W-1:0] addrX_out,
    output logic              readX_out,
    input  logic [DATA_W-1:0] dataX_in,
    output logic [ADDR_W-1:0] addrY_out,
    output logic              readY_out,
    input  logic [DATA_W-1:0] dataY_in,
    output logic [ADDR_W:0]   addrZ_out,
    output logic [Z_W-1:0]    dataZ_out,
    output logic              writeZ_out,
    output logic [ADDR_W:0]   zlen_out,
    output logic              busy_out,
    output logic              done_out
);

    localparam int IW = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                    r_state;
    logic [ADDR_W-1:0]         r_sx;
    logic [ADDR_W-1:0]         r_sy;
    logic [IW-1:0]             r_i;
    logic [IW-1:0]             r_ilast;
    logic [IW-1:0]             r_k;
    logic [ADDR_W-1:0]         r_j;
    logic [ADDR_W-1:0]         r_jhi;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_rd_d;

    // Term bounds for the current output index i
    logic [IW-1:0]             w_ip1;
    logic [ADDR_W-1:0]         w_jlo;
    logic [ADDR_W-1:0]         w_sxm1;
    logic [ADDR_W-1:0]         w_jhi;
    logic [ADDR_W-1:0]         w_jn;
    logic                      w_empty;

    assign w_ip1   = r_i + IW'(1);
    assign w_jlo   = (w_ip1 > {1'b0, r_sy}) ? ADDR_W'(w_ip1 - {1'b0, r_sy}) : '0;
    assign w_sxm1  = r_sx - ADDR_W'(1);
    assign w_jhi   = (r_i < {1'b0, w_sxm1}) ? ADDR_W'(r_i) : w_sxm1;
    assign w_jn    = r_j + ADDR_W'(1);
    assign w_empty = (sizeX_in == '0) || (sizeY_in == '0) ||
                     (mode_in && (sizeX_in < sizeY_in));

    // MAC datapath: product of the data returned for last cycle's read strobe
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_term;
    logic signed [ACC_W-1:0]    w_acc_next;
    logic [ACC_W-Z_W:0]         w_top;
    logic                       w_fits;
    logic [Z_W-1:0]             w_sat;

    assign w_prod     = $signed(dataX_in) * $signed(dataY_in);
    assign w_term     = r_rd_d ? {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod} : '0;
    assign w_acc_next = r_acc + w_term;
    // Fits in Z_W bits when all bits from the Z sign bit upward agree
    assign w_top      = w_acc_next[ACC_W-1:Z_W-1];
    assign w_fits     = (&w_top) | ~(|w_top);
    assign w_sat      = w_fits ? w_acc_next[Z_W-1:0] :
                        (w_acc_next[ACC_W-1] ? {1'b1, {(Z_W-1){1'b0}}}
                                             : {1'b0, {(Z_W-1){1'b1}}});

    // Accumulator: cleared per output in SETUP, otherwise adds one product per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_rd_d <= 1'b0;
        end else begin
            r_rd_d <= readX_out;
            r_acc  <= (r_state == S_SETUP) ? '0 : w_acc_next;
        end
    end

    // Control FSM with registered strobes, addresses and status
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sx       <= '0;
            r_sy       <= '0;
            r_i        <= '0;
            r_ilast    <= '0;
            r_k        <= '0;
            r_j        <= '0;
            r_jhi      <= '0;
            addrX_out  <= '0;
            readX_out  <= 1'b0;
            addrY_out  <= '0;
            readY_out  <= 1'b0;
            addrZ_out  <= '0;
            dataZ_out  <= '0;
            writeZ_out <= 1'b0;
            zlen_out   <= '0;
            busy_out   <= 1'b0;
            done_out   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (init_in) begin
                        r_sx <= sizeX_in;
                        r_sy <= sizeY_in;
                        r_k  <= '0;
                        if (mode_in) begin
                            r_i     <= {1'b0, sizeY_in} - IW'(1);
                            r_ilast <= {1'b0, sizeX_in} - IW'(1);
                        end else begin
                            r_i     <= '0;
                            r_ilast <= {1'b0, sizeX_in} + {1'b0, sizeY_in} - IW'(2);
                        end
                        if (w_empty) begin
                            zlen_out <= '0;
                            done_out <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            busy_out <= 1'b1;
                            r_state  <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    r_j       <= w_jlo;
                    r_jhi     <= w_jhi;
                    addrX_out <= w_jlo;
                    addrY_out <= ADDR_W'(r_i - {1'b0, w_jlo});
                    readX_out <= 1'b1;
                    readY_out <= 1'b1;
                    r_state   <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (r_j == r_jhi) begin
                        readX_out <= 1'b0;
                        readY_out <= 1'b0;
                        r_state   <= S_DRAIN;
                    end else begin
                        r_j       <= w_jn;
                        addrX_out <= w_jn;
                        addrY_out <= ADDR_W'(r_i - {1'b0, w_jn});
                    end
                end
                S_DRAIN: begin
                    // Last product lands in w_acc_next this cycle
                    writeZ_out <= 1'b1;
                    addrZ_out  <= r_k;
                    dataZ_out  <= w_sat;
                    r_state    <= S_WRITE;
                end
                S_WRITE: begin
                    writeZ_out <= 1'b0;
                    r_k        <= r_k + IW'(1);
                    if (r_i == r_ilast) begin
                        zlen_out <= r_k + IW'(1);
                        busy_out <= 1'b0;
                        done_out <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_i     <= w_ip1;
                        r_state <= S_SETUP;
                    end
                end
                S_DONE: begin
                    if (!init_in) begin
                        done_out <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_conv1d_mac_engine.sv
// ============================================================================
// Module  : tb_conv1d_mac_engine
// Purpose : Scoreboard bench for conv1d_mac_engine with X/Y memory models
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv1d_mac_engine;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int ACCW = 32;
    localparam int ZW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_in = 1'b0;
    logic          mode_in = 1'b0;
    logic [AW-1:0] sizeX_in = '0;
    logic [AW-1:0] sizeY_in = '0;
    logic [AW-1:0] addrX_out;
    logic          readX_out;
    logic [DW-1:0] dataX_in = '0;
    logic [AW-1:0] addrY_out;
    logic          readY_out;
    logic [DW-1:0] dataY_in = '0;
    logic [AW:0]   addrZ_out;
    logic [ZW-1:0] dataZ_out;
    logic          writeZ_out;
    logic [AW:0]   zlen_out;
    logic          busy_out;
    logic          done_out;

    conv1d_mac_engine #(.DATA_W(DW), .ADDR_W(AW), .ACC_W(ACCW), .Z_W(ZW)) dut (
        .clk(clk), .rst(rst), .init_in(init_in), .mode_in(mode_in),
        .sizeX_in(sizeX_in), .sizeY_in(sizeY_in),
        .addrX_out(addrX_out), .readX_out(readX_out), .dataX_in(dataX_in),
        .addrY_out(addrY_out), .readY_out(readY_out), .dataY_in(dataY_in),
        .addrZ_out(addrZ_out), .dataZ_out(dataZ_out), .writeZ_out(writeZ_out),
        .zlen_out(zlen_out), .busy_out(busy_out), .done_out(done_out)
    );

    always #5 clk = ~clk;

    int memx [32];
    int memy [32];

    typedef struct { int cyc; int addr; int val; } exp_t;
    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int edges = 0;
    int base  = 0;
    int run_sx = 0;
    int run_sy = 0;
    int reads_seen = 0;
    int strobes_seen = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Single-port memories: data returned one cycle after a read strobe, junk otherwise
    always @(posedge clk) begin
        edges++;
        dataX_in <= readX_out ? DW'(memx[addrX_out]) : DW'($urandom);
        dataY_in <= readY_out ? DW'(memy[addrY_out]) : DW'($urandom);
    end

    // Monitor: pops the scoreboard on every Z write, tracks read activity
    always @(negedge clk) begin
        if (!rst) begin
            if (readX_out || readY_out || writeZ_out) strobes_seen++;
            if (readX_out) begin
                reads_seen++;
                if (int'(addrX_out) >= run_sx || int'(addrY_out) >= run_sy || !readY_out) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL read_range: addrX=%0d addrY=%0d readY=%0b sizes %0d/%0d",
                             addrX_out, addrY_out, readY_out, run_sx, run_sy);
                end
            end
            if (writeZ_out) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: addr=%0d data=%0d", addrZ_out, $signed(dataZ_out));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("z_addr", longint'(addrZ_out), e.addr);
                    chk("z_data", longint'($signed(dataZ_out)), e.val);
                    chk("z_cycle", edges - base, e.cyc);
                end
            end
        end
    end

    function automatic int sat(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    // Reference model: convolution sums straight from the definition
    task automatic build_expect(input bit m, input int sx, input int sy,
                                output int zlen, output int done_cyc, output int nreads);
        int lo, hi, cyc, k;
        exp_q.delete();
        nreads = 0;
        if (sx == 0 || sy == 0 || (m && sx < sy)) begin
            zlen = 0;
            done_cyc = 1;
            return;
        end
        lo = m ? sy - 1 : 0;
        hi = m ? sx - 1 : sx + sy - 2;
        cyc = 0;
        k = 0;
        for (int i = lo; i <= hi; i++) begin
            longint s;
            int n;
            exp_t e;
            s = 0;
            n = 0;
            for (int j = 0; j < sx; j++) begin
                if (i - j >= 0 && i - j < sy) begin
                    s += longint'(memx[j]) * longint'(memy[i - j]);
                    n++;
                end
            end
            cyc += n + 3;
            nreads += n;
            e.cyc = cyc;
            e.addr = k;
            e.val = sat(s);
            exp_q.push_back(e);
            k++;
        end
        zlen = k;
        done_cyc = cyc + 1;
    endtask

    task automatic start(input bit m, input int sx, input int sy);
        @(negedge clk);
        init_in  = 1'b1;
        mode_in  = m;
        sizeX_in = AW'(sx);
        sizeY_in = AW'(sy);
        run_sx = sx;
        run_sy = sy;
        reads_seen = 0;
        strobes_seen = 0;
        base = edges;
    endtask

    task automatic run(input bit m, input int sx, input int sy, input bit scramble, input int hold);
        int zl, dc, nr, cnt;
        bit seen;
        build_expect(m, sx, sy, zl, dc, nr);
        start(m, sx, sy);
        cnt = 0;
        seen = 1'b0;
        while (!seen && cnt < 4000) begin
            @(negedge clk);
            cnt++;
            if (done_out) seen = 1'b1;
            else if (scramble) begin
                sizeX_in = AW'($urandom);
                sizeY_in = AW'($urandom);
                mode_in  = 1'($urandom);
                init_in  = 1'($urandom);
            end
        end
        if (!seen) begin
            chk("done_timeout", 0, 1);
            exp_q.delete();
        end else begin
            chk("done_cycle", edges - base, dc);
            chk("busy_at_done", busy_out, 0);
            chk("zlen", zlen_out, zl);
            chk("reads", reads_seen, nr);
            chk("pending_writes", exp_q.size(), 0);
            if (nr == 0) chk("empty_strobes", strobes_seen, 0);
        end
        if (hold > 0) begin
            init_in = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                chk("hold_done", {done_out, busy_out, readX_out, writeZ_out}, 4'b1000);
            end
        end
        init_in = 1'b0;
        @(negedge clk);
        chk("idle_after_done", {done_out, busy_out}, 2'b00);
    endtask

    task automatic load_test1();
        for (int i = 0; i < 32; i++) begin memx[i] = 0; memy[i] = 0; end
        memx[0] = 1; memx[1] = 2; memx[2] = 3;
        memy[0] = 1; memy[1] = 1;
    endtask

    initial begin
        int zl, dc, nr;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {addrX_out, readX_out, addrY_out, readY_out, addrZ_out, dataZ_out,
                              writeZ_out, zlen_out, busy_out, done_out}, 0);
        rst = 1'b0;

        // Directed: full and valid convolution of small vectors
        load_test1();
        run(1'b0, 3, 2, 1'b0, 0);
        run(1'b1, 3, 2, 1'b1, 0);

        // Saturation, positive and negative
        for (int i = 0; i < 4; i++) begin memx[i] = 127; memy[i] = 127; end
        run(1'b0, 4, 4, 1'b0, 0);
        for (int i = 0; i < 4; i++) memx[i] = -128;
        run(1'b0, 4, 4, 1'b0, 0);

        // Empty runs
        run(1'b0, 0, 5, 1'b0, 0);
        run(1'b1, 2, 3, 1'b0, 0);
        run(1'b0, 4, 0, 1'b0, 0);

        // Reset in cycle 7 of a run, then a clean re-run
        load_test1();
        build_expect(1'b0, 3, 2, zl, dc, nr);
        start(1'b0, 3, 2);
        while (edges - base < 7) @(negedge clk);
        rst = 1'b1;
        init_in = 1'b0;
        @(negedge clk);
        chk("midrun_reset", {addrX_out, readX_out, addrY_out, readY_out, addrZ_out, dataZ_out,
                             writeZ_out, zlen_out, busy_out, done_out}, 0);
        rst = 1'b0;
        exp_q.delete();
        run(1'b0, 3, 2, 1'b0, 0);

        // Holding init past DONE must not restart
        run(1'b0, 3, 2, 1'b0, 5);

        // Randomized runs
        for (int t = 0; t < 40; t++) begin
            int sx, sy;
            for (int i = 0; i < 32; i++) begin
                memx[i] = $signed(8'($urandom));
                memy[i] = $signed(8'($urandom));
            end
            if (t % 8 == 0) for (int i = 0; i < 32; i++) begin memx[i] = 127; memy[i] = -128; end
            sx = (t % 2) ? $urandom_range(0, 31) : $urandom_range(0, 8);
            sy = (t % 3) ? $urandom_range(0, 8) : $urandom_range(0, 31);
            run(1'($urandom), sx, sy, 1'b1, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/conv1d_mac_engine.md
# conv1d_mac_engine

Parametrised 1-D convolution engine, the next generation of the conv processor's controller. It embeds the address/length bookkeeping that the previous FSM took from external comparators, and adds a pipelined signed MAC that sustains one product per cycle. It adds two run modes (full, valid) and saturating output narrowing. It sits between the host register interface (init/sizes/busy/done) and three single-port memories: X and Y read-only, Z write-only.

## Interface
Parameters:
- DATA_W, 8, signed sample width of X and Y
- ADDR_W, 5, X/Y address width; sizes range 0..2^ADDR_W-1
- ACC_W, 32, signed accumulator width; must be ≥ 2*DATA_W+ADDR_W
- Z_W, 16, signed output sample width; Z_W ≤ ACC_W

Ports (reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- init_in  in  1  start request (level)
- mode_in  in  1  0 = full convolution, 1 = valid-only
- sizeX_in  in  ADDR_W  length of X
- sizeY_in  in  ADDR_W  length of Y
- addrX_out  out  ADDR_W  X read address
- readX_out  out  1  X read strobe
- dataX_in  in  DATA_W  X data, valid 1 cycle after readX_out
- addrY_out  out  ADDR_W  Y read address
- readY_out  out  1  Y read strobe
- dataY_in  in  DATA_W  Y data, valid 1 cycle after readY_out
- addrZ_out  out  ADDR_W+1  Z write address
- dataZ_out  out  Z_W  Z write data
- writeZ_out  out  1  Z write strobe
- zlen_out  out  ADDR_W+1  Z samples written in last run
- busy_out  out  1  run in progress
- done_out  out  1  run complete, held until init_in low

## Operation
- Z[k] = Σ X[j]·Y[i−j], over j_lo=max(0,i−sizeY+1) to j_hi=min(i,sizeX−1).
- Full mode: i = 0..sizeX+sizeY−2 and k = i.
- Valid mode: i = sizeY−1..sizeX−1 and k = i−(sizeY−1).
- sizes and mode are captured in IDLE when init_in=1; later changes are ignored until the next run.
- Empty run: sizeX=0, sizeY=0, or valid mode with sizeX<sizeY. The engine goes IDLE→DONE directly, with no reads or writes and zlen_out=0.
- FSM states: IDLE, SETUP, ISSUE, DRAIN, WRITE, DONE.
- IDLE: on init_in=1, capture inputs; go to SETUP, or to DONE if the run is empty.
- SETUP: clear the accumulator, compute j_lo/j_hi for the current i, set j=j_lo; go to ISSUE.
- ISSUE: drive readX/readY=1, addrX=j, addrY=i−j. If j==j_hi go to DRAIN, else j++.
- MAC: each cycle after a read strobe, acc += sign-extended dataX·dataY at full ACC_W precision.
- DRAIN: last product accumulates; go to WRITE.
- WRITE: writeZ=1, addrZ=k, dataZ=sat(acc). Saturation clamps to [−2^(Z_W−1), 2^(Z_W−1)−1]. If i is the last index go to DONE, else i++ and go to SETUP.
- DONE: done_out=1, zlen_out = count of writes; return to IDLE when init_in=0.
- busy_out=1 in SETUP/ISSUE/DRAIN/WRITE.
- init_in deasserting mid-run has no effect.

## Timing
- Reset: FSM=IDLE; all strobes, busy_out, done_out = 0; addresses, dataZ_out, zlen_out, acc = 0.
- rst asserted mid-run: next cycle is IDLE; no further reads or writes; the partial Z is not completed.
- Per output with n terms: n+3 cycles (SETUP + n ISSUE + DRAIN + WRITE).
- Strobes and addresses are registered outputs, valid in the state cycle.
- Run latency (init sampled at edge 0): first WRITE in cycle 3+n0; done_out high the cycle after the last WRITE.
- Empty run: done_out high in cycle 1.
- A new run needs init_in low for at least one cycle after DONE.

## Test plan
- Full, X=[1,2,3], Y=[1,1], init at cycle 0 → writes Z=[1,3,5,3] at addr 0..3 in cycles 4,9,14,18; done in cycle 19; zlen=4.
- Valid, same data → Z=[3,5] at addr 0,1; zlen=2; no write at addr ≥2.
- Saturation, full, X=Y=[127,127,127,127] → Z[3]=32767 (raw 64516); Z[0]=16129. Negative case X=[−128]×4, Y=[127]×4 → Z[3]=−32768.
- Empty runs: sizeX=0; then valid mode with sizeX=2, sizeY=3 → done in cycle 1, no strobes, zlen=0.
- Reset mid-run: rst in cycle 7 of the first test → from cycle 8 all outputs zero, FSM idle. A re-init then produces the complete correct result.
- Handshake: hold init_in=1 past DONE → done_out stays 1, no restart. Drop init_in → IDLE next cycle. Changing sizes mid-run does not alter the results.
